// File: rtl/mux_arb.sv
// mux_arb: round-robin arbiter/sequencer in front of an 8-bit 2:1 data mux.
// Two requesters (A, B) share one registered valid/ready output stage.
// A grant lasts up to BURST accepted beats while the other side is waiting,
// then ownership flips directly (no bubble). The select `s` follows the
// mux convention: 1 routes A, 0 routes B.
module mux_arb #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             x_valid,
    output logic [WIDTH-1:0] x_data,
    input  logic             x_ready,
    output logic             s,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEL_A = 2'd1;
    localparam logic [1:0] SEL_B = 2'd2;

    // Count value of the final beat in a burst (4-bit counter, BURST <= 16).
    localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

    logic [1:0]       state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             last_a_reg, last_a_next;   // 1: A was served last
    logic             s_reg, s_next;
    logic             x_valid_reg, x_valid_next;
    logic [WIDTH-1:0] x_data_reg, x_data_next;

    logic             space;
    logic             accept_a;
    logic             accept_b;
    logic [WIDTH-1:0] sel_data;

    // Output register can take a word when empty or being drained this cycle.
    assign space    = ~x_valid_reg | x_ready;
    assign a_ready  = (state_reg == SEL_A) & space;
    assign b_ready  = (state_reg == SEL_B) & space;
    assign accept_a = a_valid & a_ready;
    assign accept_b = b_valid & b_ready;

    // The shared 2:1 data mux, steered by the registered select.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign sel_data[gi] = s_reg ? a_data[gi] : b_data[gi];
        end
    endgenerate

    assign x_valid = x_valid_reg;
    assign x_data  = x_data_reg;
    assign s       = s_reg;
    assign busy    = (state_reg != IDLE) | x_valid_reg;

    // Grant FSM: picks an owner, counts burst beats, yields on burst end or drop.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        last_a_next = last_a_reg;
        s_next      = s_reg;
        case (state_reg)
            IDLE: begin
                // On a tie the side not served last wins.
                if (a_valid && (!b_valid || !last_a_reg)) begin
                    state_next  = SEL_A;
                    cnt_next    = 4'd0;
                    last_a_next = 1'b1;
                    s_next      = 1'b1;
                end else if (b_valid) begin
                    state_next  = SEL_B;
                    cnt_next    = 4'd0;
                    last_a_next = 1'b0;
                    s_next      = 1'b0;
                end
            end
            SEL_A: begin
                if (accept_a) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next = 4'd0;
                        if (b_valid) begin
                            state_next  = SEL_B;
                            last_a_next = 1'b0;
                            s_next      = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else if (!a_valid) begin
                    cnt_next = 4'd0;
                    if (b_valid) begin
                        state_next  = SEL_B;
                        last_a_next = 1'b0;
                        s_next      = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
                // a_valid with no space: hold everything.
            end
            SEL_B: begin
                if (accept_b) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next = 4'd0;
                        if (a_valid) begin
                            state_next  = SEL_A;
                            last_a_next = 1'b1;
                            s_next      = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else if (!b_valid) begin
                    cnt_next = 4'd0;
                    if (a_valid) begin
                        state_next  = SEL_A;
                        last_a_next = 1'b1;
                        s_next      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Output stage: load on accept, drain on x_ready, otherwise hold.
    always_comb begin
        x_valid_next = x_valid_reg;
        x_data_next  = x_data_reg;
        if (accept_a || accept_b) begin
            x_valid_next = 1'b1;
            x_data_next  = sel_data;
        end else if (x_ready) begin
            x_valid_next = 1'b0;
        end
    end

    // State registers; reset discards any word held in the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            last_a_reg  <= 1'b0;
            s_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            x_data_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_a_reg  <= last_a_next;
            s_reg       <= s_next;
            x_valid_reg <= x_valid_next;
            x_data_reg  <= x_data_next;
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: directed bench for mux_arb with a transaction-level model of
// grant ownership and the output register, compared every cycle, plus
// hand-computed sequences and latencies for each scenario.
module tb_mux_arb;

    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic             clk     = 1'b0;
    logic             clk_run = 1'b0;
    logic             rst     = 1'b0;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data  = '0;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data  = '0;
    logic             x_ready = 1'b0;
    logic             a_ready;
    logic             b_ready;
    logic             x_valid;
    logic [WIDTH-1:0] x_data;
    logic             s;
    logic             busy;

    mux_arb #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .x_valid (x_valid),
        .x_data  (x_data),
        .x_ready (x_ready),
        .s       (s),
        .busy    (busy)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Stimulus: per-requester word queues, enables, and downstream ready.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit a_en, b_en, xr;

    // Observed output transfers (word and the cycle it left the DUT).
    logic [7:0] emit_d[$];
    int         emit_c[$];

    // Samples of the last cycle for scenario-level checks.
    logic smp_s, smp_xv, smp_ar, smp_br;
    logic [7:0] smp_xd;

    // Model: who owns the path (0 none, 1 A, 2 B), beats delivered in the
    // current grant, who was served last, select and the output register.
    int         m_owner;
    int         m_beats;
    bit         m_last_a;
    bit         m_s;
    bit         m_xv;
    logic [7:0] m_xd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_beats  = 0;
        m_last_a = 1'b0;
        m_s      = 1'b0;
        m_xv     = 1'b0;
        m_xd     = 8'h00;
    endtask

    task automatic give(input int who);
        m_owner  = who;
        m_beats  = 0;
        m_last_a = (who == 1);
        m_s      = (who == 1);
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cycle();
        bit sp, acc_a, acc_b;
        a_valid = a_en && (qa.size() > 0);
        a_data  = 8'h00;
        if (a_valid) a_data = qa[0];
        b_valid = b_en && (qb.size() > 0);
        b_data  = 8'h00;
        if (b_valid) b_data = qb[0];
        x_ready = xr;
        #1;
        sp = !m_xv || xr;
        chk("s",       32'(s),       32'(m_s));
        chk("x_valid", 32'(x_valid), 32'(m_xv));
        chk("x_data",  32'(x_data),  32'(m_xd));
        chk("a_ready", 32'(a_ready), 32'(m_owner == 1 && sp));
        chk("b_ready", 32'(b_ready), 32'(m_owner == 2 && sp));
        chk("busy",    32'(busy),    32'(m_owner != 0 || m_xv));
        smp_s  = s;
        smp_xv = x_valid;
        smp_ar = a_ready;
        smp_br = b_ready;
        smp_xd = x_data;
        if (x_valid && x_ready) begin
            emit_d.push_back(x_data);
            emit_c.push_back(cyc);
            $display("xfer cyc=%0d data=%02h s=%0d", cyc, x_data, s);
        end
        acc_a = a_valid && (m_owner == 1) && sp;
        acc_b = b_valid && (m_owner == 2) && sp;
        if (acc_a) begin
            m_xv = 1'b1;
            m_xd = a_data;
        end else if (acc_b) begin
            m_xv = 1'b1;
            m_xd = b_data;
        end else if (xr) begin
            m_xv = 1'b0;
        end
        case (m_owner)
            0: begin
                if (a_valid && (!b_valid || !m_last_a)) give(1);
                else if (b_valid) give(2);
            end
            1: begin
                if (acc_a) begin
                    m_beats++;
                    if (m_beats == BURST) begin
                        m_beats = 0;
                        if (b_valid) give(2);
                    end
                end else if (!a_valid) begin
                    m_beats = 0;
                    if (b_valid) give(2);
                    else m_owner = 0;
                end
            end
            default: begin
                if (acc_b) begin
                    m_beats++;
                    if (m_beats == BURST) begin
                        m_beats = 0;
                        if (a_valid) give(1);
                    end
                end else if (!b_valid) begin
                    m_beats = 0;
                    if (a_valid) give(1);
                    else m_owner = 0;
                end
            end
        endcase
        if (acc_a) void'(qa.pop_front());
        if (acc_b) void'(qb.pop_front());
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        a_en = 1'b0;
        b_en = 1'b0;
        xr   = 1'b1;
        repeat (3) cycle();
        qa.delete();
        qb.delete();
        emit_d.delete();
        emit_c.delete();
    endtask

    task automatic chk_seq(input string name, input logic [7:0] exp_d[], input int first_cyc);
        chk({name, "_count"}, 32'(emit_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < emit_d.size()) begin
                chk({name, "_data"}, 32'(emit_d[i]), 32'(exp_d[i]));
                chk({name, "_cyc"},  32'(emit_c[i]), 32'(first_cyc + i));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [7:0] exp_single[]  = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        logic [7:0] exp_yield[]   = '{8'h21, 8'h22, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        logic [7:0] exp_contend[] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                                      8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        logic [7:0] exp_bp[]      = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h51, 8'h52, 8'h53, 8'h54};

        model_reset();
        a_en = 1'b0;
        b_en = 1'b0;
        xr   = 1'b0;

        // Reset with the clock stopped.
        #1 rst = 1'b1;
        #2;
        chk("rst_s",       32'(s),       32'd0);
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_x_data",  32'(x_data),  32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Single requester A, six words back to back.
        for (int i = 0; i < 6; i++) qa.push_back(8'(8'h11 + i));
        c0 = cyc; a_en = 1'b1; b_en = 1'b0; xr = 1'b1;
        cycle();
        chk("single_ar_first", 32'(smp_ar), 32'd0);
        cycle();
        chk("single_ar_grant", 32'(smp_ar), 32'd1);
        chk("single_s_grant",  32'(smp_s),  32'd1);
        repeat (8) cycle();
        chk_seq("single", exp_single, c0 + 2);
        settle();

        // Early yield: A sends two words and drops while B waits.
        qa.push_back(8'h21); qa.push_back(8'h22);
        for (int i = 0; i < 6; i++) qb.push_back(8'(8'h31 + i));
        c0 = cyc; a_en = 1'b1; b_en = 1'b0; xr = 1'b1;
        cycle();
        b_en = 1'b1;
        repeat (3) cycle();
        cycle();
        chk("yield_s",  32'(smp_s),  32'd0);
        chk("yield_br", 32'(smp_br), 32'd1);
        repeat (10) cycle();
        chk("yield_count", 32'(emit_d.size()), 32'(exp_yield.size()));
        for (int i = 0; i < exp_yield.size() && i < emit_d.size(); i++)
            chk("yield_data", 32'(emit_d[i]), 32'(exp_yield[i]));
        if (emit_d.size() >= 6) begin
            chk("yield_gap",   32'(emit_c[2]), 32'(emit_c[1] + 2));
            chk("yield_burst", 32'(emit_c[5]), 32'(emit_c[2] + 3));
        end
        settle();

        // Contention: both streams continuously valid.
        for (int i = 0; i < 8; i++) begin
            qa.push_back(8'(8'hA0 + i));
            qb.push_back(8'(8'hB0 + i));
        end
        c0 = cyc; a_en = 1'b1; b_en = 1'b1; xr = 1'b1;
        repeat (20) cycle();
        chk_seq("contend", exp_contend, c0 + 2);
        settle();

        // Backpressure for three cycles after the second A beat is presented.
        for (int i = 0; i < 4; i++) begin
            qa.push_back(8'(8'h41 + i));
            qb.push_back(8'(8'h51 + i));
        end
        c0 = cyc; a_en = 1'b1; b_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            xr = !(i >= 3 && i <= 5);
            cycle();
            if (i >= 3 && i <= 5) begin
                chk("bp_x_data",  32'(smp_xd), 32'h42);
                chk("bp_x_valid", 32'(smp_xv), 32'd1);
                chk("bp_a_ready", 32'(smp_ar), 32'd0);
            end
        end
        chk("bp_count", 32'(emit_d.size()), 32'(exp_bp.size()));
        for (int i = 0; i < exp_bp.size() && i < emit_d.size(); i++)
            chk("bp_data", 32'(emit_d[i]), 32'(exp_bp[i]));
        if (emit_d.size() >= 5) begin
            chk("bp_release_cyc", 32'(emit_c[1]), 32'(c0 + 6));
            chk("bp_switch_cyc",  32'(emit_c[4]), 32'(c0 + 9));
        end
        settle();

        // Reset in the middle of an A burst while the output holds a word.
        for (int i = 0; i < 8; i++) begin
            qa.push_back(8'(8'h61 + i));
            qb.push_back(8'(8'h71 + i));
        end
        a_en = 1'b1; b_en = 1'b1; xr = 1'b1;
        repeat (4) cycle();
        #2 rst = 1'b1;
        #1;
        chk("mrst_x_valid", 32'(x_valid), 32'd0);
        chk("mrst_s",       32'(s),       32'd0);
        chk("mrst_a_ready", 32'(a_ready), 32'd0);
        chk("mrst_busy",    32'(busy),    32'd0);
        model_reset();
        emit_d.delete();
        emit_c.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        cycle();
        chk("mrst_regrant_s",  32'(smp_s),  32'd1);
        chk("mrst_regrant_ar", 32'(smp_ar), 32'd1);
        repeat (12) cycle();
        if (emit_d.size() > 0) chk("mrst_first_word", 32'(emit_d[0]), 32'h64);
        else chk("mrst_first_word", 32'hFFFF_FFFF, 32'h64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
Name: mux_arb

Overview:
- Round-robin arbiter and sequencer for the 8-bit 2:1 data mux; shares one output path between requester A and requester B.
- Drives the select `s` with the mux convention: `s`=1 selects A, `s`=0 selects B.
- Registers the selected word into a valid/ready output stage.
- Grants bursts of up to BURST beats per requester, then yields to the other requester if it is waiting.

Parameters:
- WIDTH, 8, data width of a, b, x.
- BURST, 4, max consecutive beats per grant when the other requester is waiting; legal range 1..16.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A has a word.
- a_data  input  WIDTH  requester A word.
- a_ready  output  1  A word accepted this cycle when a_valid&a_ready.
- b_valid  input  1  requester B has a word.
- b_data  input  WIDTH  requester B word.
- b_ready  output  1  B word accepted this cycle when b_valid&b_ready.
- x_valid  output  1  output register holds a word.
- x_data  output  WIDTH  output word.
- x_ready  input  1  downstream accepts x when x_valid&x_ready.
- s  output  1  current select: 1=A, 0=B.
- busy  output  1  state!=IDLE or x_valid.

Behaviour:
- Reset (asynchronous, no clock needed):
  - state=IDLE, s=0, x_valid=0, x_data=0, burst cnt=0, last-served=B (A wins the first tie).
  - Any word in the output register is discarded; a reset mid-burst drops it.
- States:
  - IDLE: no grant.
  - SEL_A: s=1.
  - SEL_B: s=0.
- Output stage:
  - `space` = ~x_valid | x_ready.
  - a_ready = (state==SEL_A) & space.
  - b_ready = (state==SEL_B) & space.
  - Never both high; both low in IDLE.
- On accept:
  - x_data <= (s ? a_data : b_data); x_valid <= 1.
  - Else if x_ready: x_valid <= 0.
  - x_data holds while x_valid&~x_ready.
- IDLE transitions:
  - Both valid: go to the requester not last-served.
  - One valid: go to it.
  - None: stay.
  - On entry to SEL_x: cnt=0, last-served=x, s updated the same edge.
  - No transfer happens in the IDLE cycle.
- SEL_A transitions (SEL_B symmetric):
  - Beat accepted, cnt<BURST-1: cnt++, stay.
  - Beat accepted, cnt==BURST-1: if b_valid go to SEL_B, else stay; either way cnt=0.
  - a_valid=0: if b_valid go to SEL_B, else go to IDLE; cnt=0.
  - a_valid=1 with no space: hold state, cnt unchanged.
- A switch between SEL_A and SEL_B is direct, with no bubble cycle.
- Latency:
  - Request from IDLE at cycle 0: grant at cycle 1, x_valid at cycle 2.
  - Steady state, x_ready=1: one beat per cycle.
- In IDLE, `s` holds its last value.
- Words are never lost or duplicated.
- Per-requester order is preserved.
- cnt width = 4 bits.

Test Plan:
- Reset check:
  - Stimulus: assert rst with clk stopped.
  - Required: s=0, x_valid=0, x_data=0, a_ready=b_ready=0, busy=0 immediately.
- Single requester:
  - Stimulus: A only, sends 0x11..0x16 back-to-back, x_ready=1.
  - Required:
    - a_ready rises 1 cycle after a_valid.
    - x_data = 0x11..0x16 on consecutive cycles starting 2 cycles after a_valid.
    - s=1 throughout.
    - No gap after beat 4, since B is idle.
- Contention, BURST=4:
  - Stimulus: A and B both continuously valid with streams A:0xA0.., B:0xB0.., x_ready=1.
  - Required:
    - Output sequence A0 A1 A2 A3 B0 B1 B2 B3 A4 A5 ...
    - s toggles after every 4th beat.
    - No idle cycle at switches.
- Backpressure:
  - Stimulus: x_ready=0 for 3 cycles after the 2nd A beat of a burst.
  - Required:
    - x_data stays at the 2nd word with x_valid=1.
    - a_ready=0.
    - Burst count frozen; after release the 3rd and 4th beats follow, then the switch to B.
- Early yield:
  - Stimulus: A drops a_valid after 2 beats while B is waiting.
  - Required: next cycle s=0 and b_ready=1; B gets a full 4-beat burst.
- Mid-burst reset:
  - Stimulus: assert rst between clock edges during an A burst with x_valid=1.
  - Required:
    - x_valid=0 and s=0 immediately.
    - After release with both valid, A is granted first.
